// File: rtl/ofmap_readout_ctrl_pkg.sv
// Shared types for the ofmap readout controller: FSM state encoding and
// index-width helper used to size the lane and latency counters.
package ofmap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SW,
        SWITCH,
        WAIT_START,
        READ,
        LAT,
        SHIFT,
        DONE
    } state_t;

    // clog2 that never returns zero, so single-entry counters stay 1 bit wide
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofmap_readout_ctrl_if.sv
// Bus between the readout controller and its environment: config, bank-switch
// handshake with the main FSM, double-buffer read port and ofmap stream.
interface ofmap_readout_ctrl_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned CNT_W     = 8
);
    logic                          cfg_en;
    logic [ADDR_W:0]               cfg_num_words;
    logic                          ready_to_switch;
    logic                          start_new_read_bank;
    logic                          read_bank_ready_to_switch;
    logic                          switch;
    logic                          ren;
    logic [ADDR_W-1:0]             raddr;
    logic [NUM_LANES*DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]             ofmap_data;
    logic                          ofmap_valid;
    logic                          ofmap_ready;
    logic                          one_read_bank_done;
    logic [CNT_W-1:0]              bank_count;

    modport master (
        input  cfg_en, cfg_num_words, ready_to_switch, start_new_read_bank,
               rdata, ofmap_ready,
        output read_bank_ready_to_switch, switch, ren, raddr, ofmap_data,
               ofmap_valid, one_read_bank_done, bank_count
    );

    modport slave (
        output cfg_en, cfg_num_words, ready_to_switch, start_new_read_bank,
               rdata, ofmap_ready,
        input  read_bank_ready_to_switch, switch, ren, raddr, ofmap_data,
               ofmap_valid, one_read_bank_done, bank_count
    );
endinterface

// File: rtl/ofmap_readout_ctrl_piso.sv
// Parallel-in serial-out lane register: loads one read word and presents its
// lanes LSB-first, one per advance.
module ofmap_piso
    import ofmap_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic [NUM_LANES*DATA_W-1:0] i_word,
    input  logic                        i_advance,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_last_lane
);
    localparam int unsigned         LANE_W    = idx_width(NUM_LANES);
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);

    logic [NUM_LANES*DATA_W-1:0] r_shift;
    logic [LANE_W-1:0]           r_lane_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_lane_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_lane_cnt <= '0;
        end else if (i_advance) begin
            r_shift    <= r_shift >> DATA_W;
            r_lane_cnt <= r_lane_cnt + LANE_ONE;
        end
    end

    assign o_data      = r_shift[DATA_W-1:0];
    assign o_last_lane = (r_lane_cnt == LAST_LANE);
endmodule

// File: rtl/ofmap_readout_ctrl.sv
// Ofmap readout controller: switches the double-buffer read bank, reads each
// word and streams its lanes to the consumer with valid/ready backpressure.
module ofmap_readout_ctrl
    import ofmap_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned CNT_W     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    ofmap_readout_ctrl_if.master bus
);
    localparam int unsigned        LAT_W    = idx_width(RD_LAT);
    localparam logic [LAT_W-1:0]   LAT_INIT = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0]   LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_W:0]    WORD_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_num_words;
    logic [ADDR_W:0]     r_word_cnt;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [CNT_W-1:0]    r_bank_count;

    logic                w_advance;
    logic                w_load;
    logic                w_lat_zero;
    logic                w_last_lane;
    logic                w_last_word;
    logic                w_empty_bank;
    logic [DATA_W-1:0]   w_piso_data;

    assign w_lat_zero   = (r_lat_cnt == '0);
    assign w_load       = (r_state == LAT) && w_lat_zero;
    assign w_advance    = (r_state == SHIFT) && bus.ofmap_ready;
    assign w_last_word  = (r_word_cnt == r_num_words - WORD_ONE);
    assign w_empty_bank = (r_num_words == '0);

    ofmap_piso #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES)
    ) u_piso (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_word      (bus.rdata),
        .i_advance   (w_advance),
        .o_data      (w_piso_data),
        .o_last_lane (w_last_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:       if (bus.cfg_en) w_next = WAIT_SW;
            WAIT_SW:    if (bus.ready_to_switch) w_next = SWITCH;
            SWITCH, WAIT_START: begin
                if (bus.start_new_read_bank) begin
                    w_next = w_empty_bank ? DONE : READ;
                end else begin
                    w_next = WAIT_START;
                end
            end
            READ:       w_next = LAT;
            LAT:        if (w_lat_zero) w_next = SHIFT;
            SHIFT: begin
                if (w_advance && w_last_lane) begin
                    w_next = w_last_word ? DONE : READ;
                end
            end
            DONE:       w_next = WAIT_SW;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_words  <= '0;
            r_word_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_bank_count <= '0;
        end else begin
            if (r_state == IDLE && bus.cfg_en) begin
                r_num_words <= bus.cfg_num_words;
            end
            if (r_state == SWITCH) begin
                r_word_cnt <= '0;
            end else if (w_advance && w_last_lane && !w_last_word) begin
                r_word_cnt <= r_word_cnt + WORD_ONE;
            end
            if (r_state == READ) begin
                r_lat_cnt <= LAT_INIT;
            end else if (r_state == LAT && !w_lat_zero) begin
                r_lat_cnt <= r_lat_cnt - LAT_ONE;
            end
            if (r_state == DONE) begin
                r_bank_count <= r_bank_count + CNT_ONE;
            end
        end
    end

    always_comb begin
        bus.read_bank_ready_to_switch = (r_state == WAIT_SW);
        bus.switch                    = (r_state == SWITCH);
        bus.ren                       = (r_state == READ);
        bus.raddr                     = '0;
        bus.ofmap_valid               = (r_state == SHIFT);
        bus.ofmap_data                = '0;
        bus.one_read_bank_done        = (r_state == DONE);
        bus.bank_count                = r_bank_count;
        if (r_state == READ) begin
            bus.raddr = r_word_cnt[ADDR_W-1:0];
        end
        // Data is forced low outside SHIFT so nothing stale leaks between words
        if (r_state == SHIFT) begin
            bus.ofmap_data = w_piso_data;
        end
    end
endmodule

// File: tb/tb_ofmap_readout_ctrl.sv
// Directed bench for ofmap_readout_ctrl: RD_LAT=1 instance for the main flows,
// RD_LAT=3 / CNT_W=2 instance for latency and bank-counter wrap.
module tb_ofmap_readout_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned NL = 4;
    localparam int unsigned AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ofmap_readout_ctrl_if #(.DATA_W(DW), .NUM_LANES(NL), .ADDR_W(AW), .CNT_W(8)) ifa();
    ofmap_readout_ctrl_if #(.DATA_W(DW), .NUM_LANES(NL), .ADDR_W(AW), .CNT_W(2)) ifb();

    ofmap_readout_ctrl #(.DATA_W(DW), .NUM_LANES(NL), .ADDR_W(AW), .RD_LAT(1), .CNT_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    ofmap_readout_ctrl #(.DATA_W(DW), .NUM_LANES(NL), .ADDR_W(AW), .RD_LAT(3), .CNT_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Element value encodes bank seed, word index and lane index
    function automatic logic [15:0] beat_val(input logic [7:0] seed, input logic [7:0] w,
                                             input int unsigned l);
        return {seed, w[3:0], 4'(l)};
    endfunction

    function automatic logic [63:0] word_val(input logic [7:0] seed, input logic [7:0] w);
        return {beat_val(seed, w, 3), beat_val(seed, w, 2), beat_val(seed, w, 1), beat_val(seed, w, 0)};
    endfunction

    // Read-port models: data appears exactly RD_LAT cycles after ren, zero otherwise
    logic [7:0]  seed_a = '0, seed_b = '0;
    logic [63:0] rd_a = '0, rb0 = '0, rb1 = '0, rb2 = '0;
    always @(posedge clk) begin
        rd_a <= ifa.ren ? word_val(seed_a, ifa.raddr) : '0;
        rb0  <= ifb.ren ? word_val(seed_b, ifb.raddr) : '0;
        rb1  <= rb0;
        rb2  <= rb1;
    end
    assign ifa.rdata = rd_a;
    assign ifb.rdata = rb2;

    logic [15:0] exp_a[$], exp_b[$], acc_a[$];
    logic [7:0]  addr_a[$];
    int unsigned cyc = 0;
    int unsigned done_a = 0, done_b = 0;
    int unsigned cnt_ren_a = 0, cnt_sw_a = 0, cnt_done_a = 0, cnt_val_a = 0;
    int unsigned cnt_ren_b = 0, cnt_done_b = 0;
    int unsigned ren_cyc_a = 0, sw_cyc_a = 0, first_ren_a = 0, done_cyc_a = 0, ren_cyc_b = 0;
    bit          latp_a = 0, latp_b = 0, got_ren_a = 0, stall_a = 0;
    logic [15:0] hold_a = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_a.delete(); addr_a.delete(); exp_b.delete();
            done_a = 0; done_b = 0; stall_a = 0; latp_a = 0; latp_b = 0;
        end else begin
            chk("bank_count_a", 64'(ifa.bank_count), 64'(done_a % 256));
            chk("excl_a", 64'($countones({ifa.ren, ifa.switch, ifa.one_read_bank_done}) <= 1), 64'(1));
            if (stall_a) begin
                chk("hold_valid_a", 64'(ifa.ofmap_valid), 64'(1));
                chk("hold_data_a", 64'(ifa.ofmap_data), 64'(hold_a));
            end
            if (ifa.ren) begin
                if (addr_a.size() == 0) chk("ren_a_extra", 64'(addr_a.size()), 64'(1));
                else chk("raddr_a", 64'(ifa.raddr), 64'(addr_a.pop_front()));
                cnt_ren_a++; latp_a = 1; ren_cyc_a = cyc;
                if (!got_ren_a) begin got_ren_a = 1; first_ren_a = cyc; end
            end
            if (ifa.ofmap_valid) begin
                cnt_val_a++;
                if (latp_a) begin chk("latency_a", 64'(cyc - ren_cyc_a), 64'(2)); latp_a = 0; end
                if (ifa.ofmap_ready) begin
                    if (exp_a.size() == 0) chk("beat_a_extra", 64'(exp_a.size()), 64'(1));
                    else chk("beat_a", 64'(ifa.ofmap_data), 64'(exp_a.pop_front()));
                    acc_a.push_back(ifa.ofmap_data);
                end
            end
            stall_a = ifa.ofmap_valid && !ifa.ofmap_ready;
            hold_a  = ifa.ofmap_data;
            if (ifa.switch) begin cnt_sw_a++; sw_cyc_a = cyc; got_ren_a = 0; end
            if (ifa.one_read_bank_done) begin cnt_done_a++; done_a++; done_cyc_a = cyc; end

            chk("bank_count_b", 64'(ifb.bank_count), 64'(done_b % 4));
            chk("excl_b", 64'($countones({ifb.ren, ifb.switch, ifb.one_read_bank_done}) <= 1), 64'(1));
            if (ifb.ren) begin
                chk("raddr_b", 64'(ifb.raddr), 64'(0));
                cnt_ren_b++; latp_b = 1; ren_cyc_b = cyc;
            end
            if (ifb.ofmap_valid) begin
                if (latp_b) begin chk("latency_b", 64'(cyc - ren_cyc_b), 64'(4)); latp_b = 0; end
                if (ifb.ofmap_ready) begin
                    if (exp_b.size() == 0) chk("beat_b_extra", 64'(exp_b.size()), 64'(1));
                    else chk("beat_b", 64'(ifb.ofmap_data), 64'(exp_b.pop_front()));
                end
            end
            if (ifb.one_read_bank_done) begin cnt_done_b++; done_b++; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_bank_a(input logic [7:0] seed, input int unsigned n);
        for (int unsigned w = 0; w < n; w++) begin
            addr_a.push_back(8'(w));
            for (int unsigned l = 0; l < NL; l++) exp_a.push_back(beat_val(seed, 8'(w), l));
        end
    endtask

    task automatic wait_sw_a(input int unsigned base);
        int unsigned k = 0;
        while (cnt_sw_a == base && k < 30) begin tick(); k++; end
        chk("switch_seen_a", 64'(cnt_sw_a - base), 64'(1));
        ifa.ready_to_switch = 1'b0;
        ifa.start_new_read_bank = 1'b0;
    endtask

    task automatic wait_done_a(input int unsigned base, input bit toggle);
        int unsigned k = 0;
        while (cnt_done_a == base && k < 200) begin
            tick(); k++;
            if (toggle) ifa.ofmap_ready = ~ifa.ofmap_ready;
        end
        chk("done_seen_a", 64'(cnt_done_a - base), 64'(1));
        ifa.ofmap_ready = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ren"},   64'(ifa.ren), 64'(0));
        chk({tag, "_sw"},    64'(ifa.switch), 64'(0));
        chk({tag, "_done"},  64'(ifa.one_read_bank_done), 64'(0));
        chk({tag, "_valid"}, 64'(ifa.ofmap_valid), 64'(0));
        chk({tag, "_data"},  64'(ifa.ofmap_data), 64'(0));
        chk({tag, "_rbrts"}, 64'(ifa.read_bank_ready_to_switch), 64'(0));
        chk({tag, "_bcnt"},  64'(ifa.bank_count), 64'(0));
        chk({tag, "_raddr"}, 64'(ifa.raddr), 64'(0));
    endtask

    int unsigned r0, v0, s0, d0, k;

    initial begin
        ifa.cfg_en = 0; ifa.cfg_num_words = '0; ifa.ready_to_switch = 0;
        ifa.start_new_read_bank = 0; ifa.ofmap_ready = 1;
        ifb.cfg_en = 0; ifb.cfg_num_words = '0; ifb.ready_to_switch = 0;
        ifb.start_new_read_bank = 0; ifb.ofmap_ready = 1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 check_idle_outputs("reset");
        rst_n = 1'b1;

        // Two words, consumer always ready, start arrives in WAIT_START
        tick();
        seed_a = 8'h11; ifa.cfg_num_words = 9'd2; ifa.cfg_en = 1; tick(); ifa.cfg_en = 0;
        chk("rbrts_wait_sw", 64'(ifa.read_bank_ready_to_switch), 64'(1));
        push_bank_a(8'h11, 2); acc_a.delete();
        r0 = cnt_ren_a; s0 = cnt_sw_a; d0 = cnt_done_a;
        ifa.ready_to_switch = 1; wait_sw_a(s0);
        repeat (2) tick();
        chk("t1_no_ren_before_start", 64'(cnt_ren_a - r0), 64'(0));
        ifa.start_new_read_bank = 1; tick(); ifa.start_new_read_bank = 0;
        wait_done_a(d0, 0);
        chk("t1_bank_count", 64'(ifa.bank_count), 64'(1));
        chk("t1_ren_count", 64'(cnt_ren_a - r0), 64'(2));
        chk("t1_nbeats", 64'(acc_a.size()), 64'(8));
        chk("t1_first_beat", 64'(acc_a.size() > 0 ? acc_a[0] : 16'h0), 64'(16'h1100));
        chk("t1_last_beat", 64'(acc_a.size() > 7 ? acc_a[7] : 16'h0), 64'(16'h1113));

        // Backpressure 0101..; cfg_en outside IDLE must not change num_words
        seed_a = 8'h22; ifa.cfg_num_words = 9'd5; ifa.cfg_en = 1; tick(); ifa.cfg_en = 0;
        push_bank_a(8'h22, 2); acc_a.delete();
        r0 = cnt_ren_a; s0 = cnt_sw_a; d0 = cnt_done_a;
        ifa.ready_to_switch = 1; wait_sw_a(s0);
        ifa.start_new_read_bank = 1; tick(); ifa.start_new_read_bank = 0;
        ifa.ofmap_ready = 0;
        wait_done_a(d0, 1);
        chk("t2_bank_count", 64'(ifa.bank_count), 64'(2));
        chk("t2_ren_count", 64'(cnt_ren_a - r0), 64'(2));
        chk("t2_nbeats", 64'(acc_a.size()), 64'(8));
        chk("t2_beat5", 64'(acc_a.size() > 5 ? acc_a[5] : 16'h0), 64'(16'h2211));

        // start asserted during SWITCH: READ follows immediately
        seed_a = 8'h33; push_bank_a(8'h33, 2); acc_a.delete();
        s0 = cnt_sw_a; d0 = cnt_done_a;
        ifa.ready_to_switch = 1; ifa.start_new_read_bank = 1; wait_sw_a(s0);
        wait_done_a(d0, 0);
        chk("t3_sw_to_ren", 64'(first_ren_a - sw_cyc_a), 64'(1));
        chk("t3_bank_count", 64'(ifa.bank_count), 64'(3));
        chk("t3_nbeats", 64'(acc_a.size()), 64'(8));

        // Reset while lane 2 of word 1 is presented
        seed_a = 8'h55; push_bank_a(8'h55, 2);
        s0 = cnt_sw_a; d0 = cnt_done_a;
        ifa.ready_to_switch = 1; ifa.start_new_read_bank = 1;
        k = 0;
        while (!(ifa.ofmap_valid && ifa.ofmap_data == 16'h5512) && k < 60) begin
            @(negedge clk); k++;
            if (cnt_sw_a != s0) begin ifa.ready_to_switch = 0; ifa.start_new_read_bank = 0; end
        end
        chk("t5_reached_lane2", 64'(ifa.ofmap_data), 64'(16'h5512));
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        ifa.ready_to_switch = 0; ifa.start_new_read_bank = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_reset_idle", 64'({ifa.read_bank_ready_to_switch, ifa.ofmap_valid, ifa.ren}), 64'(0));
        end
        chk("post_reset_no_done", 64'(cnt_done_a - d0), 64'(0));

        // Empty bank: switch then done, no reads, no beats
        ifa.cfg_num_words = 9'd0; ifa.cfg_en = 1; tick(); ifa.cfg_en = 0;
        r0 = cnt_ren_a; v0 = cnt_val_a; s0 = cnt_sw_a; d0 = cnt_done_a;
        ifa.ready_to_switch = 1; ifa.start_new_read_bank = 1; wait_sw_a(s0);
        wait_done_a(d0, 0);
        chk("t4_no_ren", 64'(cnt_ren_a - r0), 64'(0));
        chk("t4_no_valid", 64'(cnt_val_a - v0), 64'(0));
        chk("t4_sw_to_done", 64'(done_cyc_a - sw_cyc_a), 64'(1));
        chk("t4_bank_count", 64'(ifa.bank_count), 64'(1));

        // RD_LAT=3, CNT_W=2: five one-word banks wrap the counter to 1
        seed_b = 8'h77;
        repeat (5) for (int unsigned l = 0; l < NL; l++) exp_b.push_back(beat_val(8'h77, 8'h00, l));
        ifb.cfg_num_words = 9'd1; ifb.cfg_en = 1; tick(); ifb.cfg_en = 0;
        r0 = cnt_ren_b; d0 = cnt_done_b;
        ifb.ready_to_switch = 1; ifb.start_new_read_bank = 1;
        k = 0;
        while (cnt_done_b - d0 < 5 && k < 300) begin tick(); k++; end
        ifb.ready_to_switch = 0; ifb.start_new_read_bank = 0;
        chk("b_done_count", 64'(cnt_done_b - d0), 64'(5));
        chk("b_ren_count", 64'(cnt_ren_b - r0), 64'(5));
        chk("b_bank_count_wrap", 64'(ifb.bank_count), 64'(1));
        chk("b_exp_drained", 64'(exp_b.size()), 64'(0));
        chk("a_exp_drained", 64'(exp_a.size()), 64'(0));

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
